// File: rtl/ball_sprite_fetch_if.sv
// Ball sprite ROM bus.
// The fetch block is the master: it presents the read address plus the
// size/fire selects. The ROM is the slave: it returns a 4-bit palette index
// combinationally from those selects.
//   rom_addr    : ROM read address (dy*w + dx of the sprite pixel)
//   rom_size    : ROM ball size select (0 = 8x8, 1 = 12x12, 2 = 16x16)
//   rom_is_fire : ROM fire-ball select
//   rom_data    : palette index returned by the ROM
interface ball_sprite_fetch_if;
  logic [18:0] rom_addr;
  logic [1:0]  rom_size;
  logic        rom_is_fire;
  logic [3:0]  rom_data;

  modport master (
    output rom_addr,
    output rom_size,
    output rom_is_fire,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_size,
    input  rom_is_fire,
    output rom_data
  );
endinterface

// File: rtl/ball_sprite_fetch.sv
// Per-pixel front end for the ball sprite ROM in the VGA merge path.
// Decides whether the beam lies inside the ball's bounding box, drives the
// ROM address/selects one cycle later and registers the returned palette
// index one further cycle later. Total latency is 2 cycles, free-running.
// Ball state is shadow-latched on frame_start so the sprite never tears.
// A saturating counter reports the opaque pixels drawn in the previous frame.
// Ports:
//   Clk, Reset     : clock, synchronous active-high reset
//   frame_start    : one-cycle pulse at the start of vertical blanking
//   ball_x, ball_y : ball centre from game control
//   ball_size_in   : 0 = 8x8, 1 = 12x12, 2/3 = 16x16
//   is_fire_in     : fire ball, always 16x16
//   DrawX, DrawY   : current beam position
//   rom            : sprite ROM bus (master side)
//   ball_on        : opaque ball pixel at the beam (2 cycles after DrawX/DrawY)
//   ball_idx       : palette index, 0 when ball_on is low
//   pix_count      : opaque ball pixels counted in the previous frame
module ball_sprite_fetch #(
  parameter int         SCREEN_W        = 640,
  parameter int         SCREEN_H        = 480,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [9:0]                 ball_x,
  input  logic [9:0]                 ball_y,
  input  logic [1:0]                 ball_size_in,
  input  logic                       is_fire_in,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  ball_sprite_fetch_if.master        rom,
  output logic                       ball_on,
  output logic [3:0]                 ball_idx,
  output logic [8:0]                 pix_count
);

  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);

  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [8:0] sat_inc(input logic [8:0] c);
    return (c == 9'h1FF) ? c : c + 9'd1;
  endfunction

  // Shadow copy of the ball state, updated only at frame boundaries.
  logic [9:0] sx, sy;
  logic [1:0] ssize;
  logic       sfire;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx    <= '0;
      sy    <= '0;
      ssize <= '0;
      sfire <= 1'b0;
    end else if (frame_start) begin
      sx    <= ball_x;
      sy    <= ball_y;
      ssize <= ball_size_in;
      sfire <= is_fire_in;
    end
  end

  // ---- stage 0: bounding-box test and address generation ----
  logic        [4:0]  r_p0, w_p0;
  logic signed [10:0] left_p0, top_p0, dx_p0, dy_p0;
  logic               hit_p0;
  logic        [8:0]  addr_p0;

  always_comb begin
    if (sfire || ssize[1]) r_p0 = 5'd8;
    else if (ssize[0])     r_p0 = 5'd6;
    else                   r_p0 = 5'd4;
    w_p0 = {r_p0[3:0], 1'b0};

    // Box origin may be negative when the ball hangs off the left/top edge;
    // the signed offsets keep those columns/rows from aliasing into hits.
    left_p0 = $signed({1'b0, sx}) - $signed({6'b0, r_p0});
    top_p0  = $signed({1'b0, sy}) - $signed({6'b0, r_p0});
    dx_p0   = $signed({1'b0, DrawX}) - left_p0;
    dy_p0   = $signed({1'b0, DrawY}) - top_p0;

    hit_p0 = !dx_p0[10] && (dx_p0[9:0] < {5'b0, w_p0}) &&
             !dy_p0[10] && (dy_p0[9:0] < {5'b0, w_p0}) &&
             ({1'b0, DrawX} < SCREEN_W_L) && ({1'b0, DrawY} < SCREEN_H_L);

    // Offsets are below 16 whenever hit_p0 is set, so 4 bits suffice.
    addr_p0 = {5'b0, dy_p0[3:0]} * {4'b0, w_p0} + {5'b0, dx_p0[3:0]};
  end

  // ---- stage 1: ROM request registers ----
  logic [18:0] addr_p1;
  logic [1:0]  size_p1;
  logic        fire_p1;
  logic        vld_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_p1 <= '0;
      size_p1 <= '0;
      fire_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      addr_p1 <= hit_p0 ? {10'b0, addr_p0} : 19'd0;
      size_p1 <= clamp_size(ssize);
      fire_p1 <= sfire;
      vld_p1  <= hit_p0;
    end
  end

  assign rom.rom_addr    = addr_p1;
  assign rom.rom_size    = size_p1;
  assign rom.rom_is_fire = fire_p1;

  // ---- stage 2: registered palette index ----
  logic       opaque_p1;
  logic       on_p2;
  logic [3:0] idx_p2;

  assign opaque_p1 = vld_p1 && (rom.rom_data != TRANSPARENT_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      on_p2  <= 1'b0;
      idx_p2 <= '0;
    end else begin
      on_p2  <= opaque_p1;
      idx_p2 <= opaque_p1 ? rom.rom_data : 4'h0;
    end
  end

  assign ball_on  = on_p2;
  assign ball_idx = idx_p2;

  // Per-frame coverage; a pixel coincident with frame_start opens the new frame.
  logic [8:0] cnt, pix_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= '0;
      pix_q <= '0;
    end else if (frame_start) begin
      pix_q <= cnt;
      cnt   <= {8'b0, on_p2};
    end else if (on_p2) begin
      cnt   <= sat_inc(cnt);
    end
  end

  assign pix_count = pix_q;

endmodule
